fibonacci_seq: RTL

Parametrised, restartable Fibonacci-type sequence generator with a valid/ready output stream. A run is started with two arbitrary seed terms and a term count. Each term is the wrapping sum of the previous two, and wrap-around is detected. It sits behind any stream consumer (display driver, UART formatter, FIFO) and replaces the fixed-width, free-running 8-bit generator.

---
 rtl/fibonacci_seq_pkg.sv | 24 ++
 rtl/fibonacci_seq_if.sv | 32 +++
 rtl/fibonacci_step.sv | 59 +++++
 rtl/fibonacci_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/fibonacci_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fibonacci_seq_pkg: shared state encoding and the carry-aware adder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fibonacci_seq_pkg;

    localparam int c_MAX_WIDTH = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Callers zero-extend narrower operands; bit WIDTH of the result is then their carry.
    function automatic logic [c_MAX_WIDTH:0] fib_add(
        input logic [c_MAX_WIDTH-1:0] a,
        input logic [c_MAX_WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fibonacci_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fibonacci_seq_if: start/seed request and term stream bundle.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fibonacci_seq_if #(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 6
);
    logic                   i_Start;
    logic [WIDTH-1:0]       i_Seed0;
    logic [WIDTH-1:0]       i_Seed1;
    logic [COUNT_WIDTH-1:0] i_Length;
    logic                   i_Ready;
    logic                   o_Busy;
    logic                   o_Valid;
    logic [WIDTH-1:0]       o_Value;
    logic [COUNT_WIDTH-1:0] o_Index;
    logic                   o_Last;
    logic                   o_Overflow;

    modport slave (
        input  i_Start, i_Seed0, i_Seed1, i_Length, i_Ready,
        output o_Busy, o_Valid, o_Value, o_Index, o_Last, o_Overflow
    );

    modport master (
        output i_Start, i_Seed0, i_Seed1, i_Length, i_Ready,
        input  o_Busy, o_Valid, o_Value, o_Index, o_Last, o_Overflow
    );
endinterface
`default_nettype wire

// File: rtl/fibonacci_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fibonacci_step: cur/nxt term pair with sticky wrap flag on nxt.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fibonacci_step
    import fibonacci_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             load_i,
    input  wire logic             advance_i,
    input  wire logic [WIDTH-1:0] seed0_i,
    input  wire logic [WIDTH-1:0] seed1_i,
    output logic      [WIDTH-1:0] cur_o,
    output logic                  nxt_ovf_o
);

    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] nxt_q, nxt_d;
    logic             nxt_ovf_q, nxt_ovf_d;
    logic [WIDTH:0]   sum_w;

    assign sum_w = (WIDTH+1)'(fib_add(c_MAX_WIDTH'(cur_q), c_MAX_WIDTH'(nxt_q)));

    always_comb begin
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        nxt_ovf_d = nxt_ovf_q;
        if (load_i) begin
            cur_d     = seed0_i;
            nxt_d     = seed1_i;
            nxt_ovf_d = 1'b0;
        end else if (advance_i) begin
            cur_d     = nxt_q;
            nxt_d     = sum_w[WIDTH-1:0];
            nxt_ovf_d = nxt_ovf_q | sum_w[WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q     <= '0;
            nxt_q     <= '0;
            nxt_ovf_q <= 1'b0;
        end else begin
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            nxt_ovf_q <= nxt_ovf_d;
        end
    end

    assign cur_o     = cur_q;
    assign nxt_ovf_o = nxt_ovf_q;

endmodule
`default_nettype wire

// File: rtl/fibonacci_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fibonacci_seq: restartable Fibonacci-type term stream (valid/ready). |
// | Option macro: FIBONACCI_SEQ_STOP_ON_OVERFLOW_EN ends run before wrap.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fibonacci_seq
    import fibonacci_seq_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int COUNT_WIDTH = 6
) (
    input  wire logic      i_Clock,
    input  wire logic      i_Reset,
    fibonacci_seq_if.slave stream
);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic                   ovf_q, ovf_d;

    logic [WIDTH-1:0]       cur_w;
    logic                   nxt_ovf_w;
    logic [COUNT_WIDTH-1:0] len_m1_w;
    logic                   count_last_w;
    logic                   last_w;
    logic                   load_w;
    logic                   xfer_w;
    logic                   advance_w;

    assign len_m1_w     = len_q - COUNT_WIDTH'(1);
    assign count_last_w = (idx_q == len_m1_w);

`ifdef FIBONACCI_SEQ_STOP_ON_OVERFLOW_EN
    // A pending wrap in nxt makes the presented term the final one.
    assign last_w = (state_q == RUN) && (count_last_w || nxt_ovf_w);
`else
    assign last_w = (state_q == RUN) && count_last_w;
`endif

    assign load_w    = (state_q == IDLE) && stream.i_Start && (stream.i_Length != '0);
    assign xfer_w    = (state_q == RUN) && stream.i_Ready;
    assign advance_w = xfer_w && !last_w;

    fibonacci_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk_i     (i_Clock),
        .rst_i     (i_Reset),
        .load_i    (load_w),
        .advance_i (advance_w),
        .seed0_i   (stream.i_Seed0),
        .seed1_i   (stream.i_Seed1),
        .cur_o     (cur_w),
        .nxt_ovf_o (nxt_ovf_w)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (load_w) begin
                    state_d = RUN;
                    idx_d   = '0;
                    len_d   = stream.i_Length;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                if (xfer_w) begin
                    if (last_w) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + COUNT_WIDTH'(1);
                        // The term about to be presented is the old nxt.
                        ovf_d = ovf_q | nxt_ovf_w;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign stream.o_Busy     = (state_q == RUN);
    assign stream.o_Valid    = (state_q == RUN);
    assign stream.o_Value    = cur_w;
    assign stream.o_Index    = idx_q;
    assign stream.o_Last     = last_w;
    assign stream.o_Overflow = ovf_q;

endmodule
`default_nettype wire
